// File: rtl/approx_mul_pipe.sv
// Two-stage pipelined unsigned multiplier with per-transaction exact/approximate mode.
// Approximate mode OR-compresses the low APPROX_K result columns; upper columns stay exact.
module approx_mul_pipe #(
    parameter int A_W      = 7,
    parameter int B_W      = 4,
    parameter int APPROX_K = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     in_a,
    input  logic [B_W-1:0]     in_b,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] out_res,
    output logic               out_approx
);

    localparam int N = A_W + B_W;

    logic [N-1:0] lo_mask;
    logic [N-1:0] pp_row   [B_W];
    logic [N-1:0] nxt_rows [B_W];
    logic [N-1:0] nxt_lo;

    logic         s1_valid;
    logic [N-1:0] s1_rows [B_W];
    logic [N-1:0] s1_lo;
    logic         s1_approx;

    logic         s2_valid;
    logic [N-1:0] s2_res;
    logic         s2_approx;

    logic [N-1:0] sum_hi;
    logic [N-1:0] sum_res;
    logic         adv1;
    logic         adv2;

    for (genvar c = 0; c < N; c++) begin : g_mask
        assign lo_mask[c] = (c < APPROX_K) ? 1'b1 : 1'b0;
    end

    // Each row is one shifted partial product; in approximate mode the low
    // columns are pulled out of the rows and ORed into a single vector.
    always_comb begin
        nxt_lo = '0;
        for (int j = 0; j < B_W; j++) begin
            pp_row[j]   = ({{B_W{1'b0}}, in_a} & {N{in_b[j]}}) << j;
            nxt_rows[j] = in_approx ? (pp_row[j] & ~lo_mask) : pp_row[j];
            nxt_lo      = nxt_lo | (in_approx ? (pp_row[j] & lo_mask) : '0);
        end
    end

    // Hi rows never touch the low columns, so OR-ing the low vector cannot carry.
    always_comb begin
        sum_hi = '0;
        for (int j = 0; j < B_W; j++) begin
            sum_hi = sum_hi + s1_rows[j];
        end
        sum_res = sum_hi | s1_lo;
    end

    assign adv2     = out_ready | ~s2_valid;
    assign adv1     = adv2 | ~s1_valid;
    assign in_ready = adv1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_rows   <= '{default: '0};
            s1_lo     <= '0;
            s1_approx <= 1'b0;
            s2_valid  <= 1'b0;
            s2_res    <= '0;
            s2_approx <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid  <= in_valid;
                s1_rows   <= nxt_rows;
                s1_lo     <= nxt_lo;
                s1_approx <= in_approx;
            end
            if (adv2) begin
                s2_valid  <= s1_valid;
                s2_res    <= sum_res;
                s2_approx <= s1_approx;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_res    = s2_res;
    assign out_approx = s2_approx;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed and scoreboarded checks for approx_mul_pipe (default build plus an APPROX_K=0 build).
module tb_approx_mul_pipe;

    localparam int A_W = 7;
    localparam int B_W = 4;
    localparam int N   = A_W + B_W;
    localparam int K   = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_approx;
    logic [A_W-1:0] in_a;
    logic [B_W-1:0] in_b;
    logic           out_valid, out_ready, out_approx;
    logic [N-1:0]   out_res;

    logic           k_valid, k_ready, k_approx;
    logic [A_W-1:0] k_a;
    logic [B_W-1:0] k_b;
    logic           k_ovalid, k_oready, k_oapprox;
    logic [N-1:0]   k_ores;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int k_out = 0;
    bit mon_en = 1'b0;
    bit held   = 1'b0;
    logic [N:0] held_val;
    logic [N:0] q[$];
    logic [N:0] kq[$];

    always #5 clk = ~clk;

    approx_mul_pipe #(.A_W(A_W), .B_W(B_W), .APPROX_K(K)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_approx(out_approx)
    );

    approx_mul_pipe #(.A_W(A_W), .B_W(B_W), .APPROX_K(0)) dut_k0 (
        .clk(clk), .rst(rst),
        .in_valid(k_valid), .in_ready(k_ready),
        .in_a(k_a), .in_b(k_b), .in_approx(k_approx),
        .out_valid(k_ovalid), .out_ready(k_oready),
        .out_res(k_ores), .out_approx(k_oapprox)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Column-wise reference: every partial-product bit is visited individually.
    function automatic int ref_mul(input int a, input int b, input bit ap, input int k);
        int hi = 0;
        int lo = 0;
        for (int i = 0; i < A_W; i++)
            for (int j = 0; j < B_W; j++)
                if (a[i] && b[j]) begin
                    if (!ap || (i + j) >= k) hi += (1 << (i + j));
                    else                     lo |= (1 << (i + j));
                end
        return hi | lo;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b, input bit ap);
        in_valid  = 1'b1;
        in_a      = a[A_W-1:0];
        in_b      = b[B_W-1:0];
        in_approx = ap;
    endtask

    task automatic dir_vec(input string tag, input int a, input int b, input bit ap, input int exp);
        drive(a, b, ap);
        @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
        check({tag, "_res"}, 32'(out_res), 32'(exp));
        check({tag, "_tag"}, 32'(out_approx), 32'(ap));
        tick();
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (held) begin
                check("stall_ov", 32'(out_valid), 32'd1);
                check("stall_data", 32'({out_approx, out_res}), 32'(held_val));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) check("extra_out", 32'(q.size()), 32'd1);
                else check("sb_res", 32'({out_approx, out_res}), 32'(q.pop_front()));
            end
            if (in_valid && in_ready)
                q.push_back({in_approx, N'(ref_mul(int'(in_a), int'(in_b), in_approx, K))});
            held     = out_valid && !out_ready;
            held_val = {out_approx, out_res};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (k_ovalid && k_oready) begin
                k_out++;
                if (kq.size() == 0) check("k0_extra", 32'(kq.size()), 32'd1);
                else check("k0_res", 32'({k_oapprox, k_ores}), 32'(kq.pop_front()));
            end
            if (k_valid && k_ready)
                kq.push_back({k_approx, N'(int'(k_a) * int'(k_b))});
        end
    end

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0; out_ready = 1'b1;
        k_valid = 1'b0; k_a = '0; k_b = '0; k_approx = 1'b0; k_oready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_res", 32'(out_res), 32'd0);
        check("rst_tag", 32'(out_approx), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        dir_vec("ex_127x15", 127, 15, 1'b0, 1905);
        dir_vec("ap_127x15", 127, 15, 1'b1, 1727);
        dir_vec("ap_3x3", 3, 3, 1'b1, 7);
        dir_vec("ap_5x3", 5, 3, 1'b1, 15);
        dir_vec("ap_zero", 0, 0, 1'b1, 0);
        dir_vec("ex_zero", 0, 9, 1'b0, 0);
        dir_vec("ap_hi_only", 64, 8, 1'b1, 512);

        // Backpressure: two accepted, third refused, data held, then all three drain in order.
        out_ready = 1'b0;
        drive(127, 15, 1'b0);
        @(negedge clk); check("bp_rdy1", 32'(in_ready), 32'd1);
        tick();
        drive(3, 3, 1'b1);
        @(negedge clk); check("bp_rdy2", 32'(in_ready), 32'd1);
        tick();
        drive(5, 3, 1'b1);
        @(negedge clk);
        check("bp_rdy3", 32'(in_ready), 32'd0);
        check("bp_ov", 32'(out_valid), 32'd1);
        check("bp_res0", 32'(out_res), 32'd1905);
        tick();
        @(negedge clk);
        check("bp_hold_res", 32'(out_res), 32'd1905);
        check("bp_hold_rdy", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        @(negedge clk); check("bp_rdy_release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_out2", 32'(out_res), 32'd7);
        check("bp_ov2", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        check("bp_out3", 32'(out_res), 32'd15);
        check("bp_tag3", 32'(out_approx), 32'd1);
        tick();
        @(negedge clk); check("bp_empty", 32'(out_valid), 32'd0);
        tick();

        // Full-rate streaming with random mode.
        mon_en = 1'b1;
        base = n_out;
        for (int i = 0; i < 200; i++) begin
            drive(int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            check("stream_rdy", 32'(in_ready), 32'd1);
            if (i >= 2) check("stream_ov", 32'(out_valid), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("stream_count", 32'(n_out - base), 32'd200);

        // Random backpressure and random input valid.
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            drive(int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            in_valid = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        tick();
        check("drain_empty", 32'(q.size()), 32'd0);
        mon_en = 1'b0;

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        drive(127, 15, 1'b0);
        tick();
        drive(3, 3, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk); check("mid_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid_ov", 32'(out_valid), 32'd0);
        check("mid_res", 32'(out_res), 32'd0);
        check("mid_rdy", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); check("mid_no_stale", 32'(out_valid), 32'd0);
            tick();
        end

        // APPROX_K=0 build: approximate must equal exact.
        base = k_out;
        for (int i = 0; i < 100; i++) begin
            k_valid  = 1'b1;
            k_a      = A_W'($urandom_range(0, 127));
            k_b      = B_W'($urandom_range(0, 15));
            k_approx = 1'b1;
            tick();
        end
        k_valid = 1'b0;
        repeat (5) tick();
        check("k0_count", 32'(k_out - base), 32'd100);
        check("k0_empty", 32'(kq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
